// File: rtl/cmd_packetizer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cmd_packetizer: serializes opcode + payload into a byte stream w/ gap   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module cmd_packetizer #(
  parameter int NUM_PKT_SOFT_RST  = 2,
  parameter int NUM_PKT_RECT_FILL = 12,
  parameter int NUM_PKT_LINE_DRAW = 12,
  parameter int GAP_CYCLES        = 2
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic [7:0]   cmd_in,
  input  logic [127:0] cmd_data_in,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  output logic         out_rts,
  input  logic         out_rtr,
  output logic [7:0]   out_data,
  output logic         busy,
  output logic         cmd_done,
  output logic         cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  // Payload index of the final byte for each supported opcode (N - 2).
  localparam logic [3:0] C_LAST_SOFT_RST  = 4'(NUM_PKT_SOFT_RST - 2);
  localparam logic [3:0] C_LAST_RECT_FILL = 4'(NUM_PKT_RECT_FILL - 2);
  localparam logic [3:0] C_LAST_LINE_DRAW = 4'(NUM_PKT_LINE_DRAW - 2);
  localparam int         C_GAP_W          = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [C_GAP_W-1:0] C_GAP_LOAD = C_GAP_W'(GAP_CYCLES - 1);

  state_t               state_q,    state_d;
  logic [7:0]           opcode_q,   opcode_d;
  logic [127:0]         data_q,     data_d;
  logic [3:0]           idx_q,      idx_d;
  logic [3:0]           last_q,     last_d;
  logic [C_GAP_W-1:0]   gap_cnt_q,  gap_cnt_d;
  logic                 cmd_done_q, cmd_done_d;
  logic                 cmd_err_q,  cmd_err_d;

  logic                 w_supported;
  logic [3:0]           w_last;
  logic                 w_xfc;

  always_comb begin
    w_supported = 1'b1;
    w_last      = 4'd0;
    case (cmd_in)
      8'h00:   w_last = C_LAST_SOFT_RST;
      8'h03:   w_last = C_LAST_RECT_FILL;
      8'h04:   w_last = C_LAST_LINE_DRAW;
      default: w_supported = 1'b0;
    endcase
  end

  // Byte outputs depend only on flops, so out_rtr never reaches out_rts.
  always_comb begin
    out_rts  = 1'b0;
    out_data = 8'h00;
    case (state_q)
      S_HEADER: begin
        out_rts  = 1'b1;
        out_data = opcode_q;
      end
      S_PAYLOAD: begin
        out_rts  = 1'b1;
        out_data = data_q[{idx_q, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign w_xfc     = out_rts & out_rtr;
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign cmd_done  = cmd_done_q;
  assign cmd_err   = cmd_err_q;

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    data_d     = data_q;
    idx_d      = idx_q;
    last_d     = last_q;
    gap_cnt_d  = gap_cnt_q;
    cmd_done_d = 1'b0;
    cmd_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (w_supported) begin
            opcode_d = cmd_in;
            data_d   = cmd_data_in;
            last_d   = w_last;
            state_d  = S_HEADER;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_HEADER: begin
        if (w_xfc) begin
          idx_d   = 4'd0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (w_xfc) begin
          if (idx_q == last_q) begin
            gap_cnt_d  = C_GAP_LOAD;
            cmd_done_d = 1'b1;
            state_d    = S_GAP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= S_IDLE;
      opcode_q   <= 8'h00;
      data_q     <= '0;
      idx_q      <= 4'd0;
      last_q     <= 4'd0;
      gap_cnt_q  <= '0;
      cmd_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      gap_cnt_q  <= gap_cnt_d;
      cmd_done_q <= cmd_done_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

endmodule
`default_nettype wire
